// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch (IF) and the data port (MEM).
// One transaction at a time, registered bus command, bounded wait with timeout abort.
module mem_bus_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  input  logic [3:0]    mem_sel,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          mem_ack,
  output logic [DW-1:0] mem_rdata,
  output logic          bus_err,
  output logic          stallreq_if,
  output logic          stallreq_mem,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  output logic [3:0]    bus_sel,
  input  logic          bus_ack,
  input  logic [DW-1:0] bus_rdata
);

  localparam int SW = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_MEM} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    sel;
  } bus_cmd_t;

  state_t        state, state_nxt;
  bus_cmd_t      cmd, cmd_nxt;
  logic [SW-1:0] streak;
  logic [7:0]    timer;
  logic          pick_if, pick_mem, tmo, done;

  always_comb begin
    pick_if   = 1'b0;
    pick_mem  = 1'b0;
    state_nxt = state;
    // MEM belongs to the older instruction, but IF is forced through once it has starved
    if (mem_req && !(if_req && streak == SW'(MAX_STREAK))) pick_mem = 1'b1;
    else if (if_req)                                       pick_if  = 1'b1;
    tmo  = !bus_ack && (timer == 8'(TIMEOUT - 1));
    done = bus_ack || tmo;
    cmd_nxt = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, sel: mem_sel};
    if (pick_if) cmd_nxt = '{we: 1'b0, addr: if_addr, wdata: '0, sel: 4'hF};
    case (state)
      IDLE:            if (pick_mem) state_nxt = GNT_MEM;
                       else if (pick_if) state_nxt = GNT_IF;
      GNT_IF, GNT_MEM: if (done) state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd       <= '0;
      streak    <= '0;
      timer     <= '0;
      bus_req   <= 1'b0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_mem || pick_if) begin
            bus_req <= 1'b1;
            cmd     <= cmd_nxt;
            timer   <= '0;
            if (pick_if || !if_req)              streak <= '0;
            else if (streak != SW'(MAX_STREAK)) streak <= streak + SW'(1);
          end
        end
        GNT_IF, GNT_MEM: begin
          if (done) begin
            bus_req <= 1'b0;
            bus_err <= tmo;
            if (state == GNT_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= tmo ? '0 : bus_rdata;
            end else begin
              mem_ack   <= 1'b1;
              mem_rdata <= (tmo || cmd.we) ? '0 : bus_rdata;
            end
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: bus_req <= 1'b0;
      endcase
    end
  end

  assign bus_we    = cmd.we;
  assign bus_addr  = cmd.addr;
  assign bus_wdata = cmd.wdata;
  assign bus_sel   = cmd.sel;

  // ack is registered, so a port stops stalling in the very cycle it is served
  assign stallreq_if  = if_req  && !if_ack  && !rst;
  assign stallreq_mem = mem_req && !mem_ack && !rst;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a registered memory responder of programmable latency.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [3:0]  mem_sel;
  logic        if_ack, mem_ack, bus_err, stallreq_if, stallreq_mem;
  logic [31:0] if_rdata, mem_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  logic        mdl_ack, man_ack;
  int          mdl_cnt;
  int          mem_lat;
  logic [31:0] mdl_rdata;
  int          nvec, nerr;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sel(mem_sel),
    .if_ack(if_ack), .if_rdata(if_rdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_err(bus_err), .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // Memory acks in the mem_lat-th cycle that bus_req is high; mem_lat == 0 never acks.
  assign bus_ack   = mdl_ack | man_ack;
  assign bus_rdata = mdl_rdata;

  always @(posedge clk) begin
    if (rst || !bus_req || mdl_ack) begin
      mdl_cnt <= 0;
      mdl_ack <= 1'b0;
    end else begin
      mdl_cnt <= mdl_cnt + 1;
      mdl_ack <= (mem_lat != 0) && (mdl_cnt + 2 == mem_lat);
    end
  end

  task automatic test_reset;
    rst = 1'b1; if_req = 0; mem_req = 0; mem_we = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_sel = 0;
    man_ack = 0; mem_lat = 2; mdl_rdata = 0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({bus_req, if_ack, mem_ack, bus_err, stallreq_if, stallreq_mem} !== 6'b0) begin
      nerr++; $display("FAIL reset_ctrl got %b want 000000",
        {bus_req, if_ack, mem_ack, bus_err, stallreq_if, stallreq_mem});
    end
    nvec++;
    if ({bus_we, bus_addr, bus_wdata, bus_sel, if_rdata, mem_rdata} !== '0) begin
      nerr++; $display("FAIL reset_data got addr %h wdata %h sel %h if_rdata %h mem_rdata %h want 0",
        bus_addr, bus_wdata, bus_sel, if_rdata, mem_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_lone_if;
    @(negedge clk);
    mem_lat = 2; mdl_rdata = 32'hDEADBEEF;
    if_req = 1; if_addr = 32'h100;
    #1;
    nvec++;
    if (stallreq_if !== 1'b1 || bus_req !== 1'b0) begin
      nerr++; $display("FAIL if_cycleN got stall %b bus_req %b want 1 0", stallreq_if, bus_req);
    end
    @(negedge clk);
    nvec++;
    if ({bus_req, bus_we, bus_addr, bus_sel, bus_wdata, stallreq_if, if_ack} !== {1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL if_cmd got req %b we %b addr %h sel %h wdata %h stall %b ack %b want 1 0 100 f 0 1 0",
        bus_req, bus_we, bus_addr, bus_sel, bus_wdata, stallreq_if, if_ack);
    end
    @(negedge clk);
    nvec++;
    if (bus_req !== 1'b1 || stallreq_if !== 1'b1 || if_ack !== 1'b0) begin
      nerr++; $display("FAIL if_wait got req %b stall %b ack %b want 1 1 0", bus_req, stallreq_if, if_ack);
    end
    @(negedge clk);
    nvec++;
    if (if_ack !== 1'b1 || if_rdata !== 32'hDEADBEEF || bus_req !== 1'b0 || stallreq_if !== 1'b0) begin
      nerr++; $display("FAIL if_ack got ack %b rdata %h req %b stall %b want 1 deadbeef 0 0",
        if_ack, if_rdata, bus_req, stallreq_if);
    end
    if_req = 0;
    @(negedge clk);
    nvec++;
    if (if_ack !== 1'b0 || bus_req !== 1'b0) begin
      nerr++; $display("FAIL if_after got ack %b req %b want 0 0", if_ack, bus_req);
    end
  endtask

  task automatic test_mem_before_if;
    @(negedge clk);
    mem_lat = 2; mdl_rdata = 32'h55AA55AA;
    if_req = 1; if_addr = 32'h300;
    mem_req = 1; mem_we = 1; mem_addr = 32'h200; mem_wdata = 32'h12345678; mem_sel = 4'b0011;
    @(negedge clk);
    nvec++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, bus_sel} !== {1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011}) begin
      nerr++; $display("FAIL both_mem_cmd got req %b we %b addr %h wdata %h sel %b want 1 1 200 12345678 0011",
        bus_req, bus_we, bus_addr, bus_wdata, bus_sel);
    end
    nvec++;
    if (stallreq_if !== 1'b1 || stallreq_mem !== 1'b1) begin
      nerr++; $display("FAIL both_stall got if %b mem %b want 1 1", stallreq_if, stallreq_mem);
    end
    repeat (2) @(negedge clk);
    nvec++;
    if (mem_ack !== 1'b1 || mem_rdata !== 32'h0 || if_ack !== 1'b0 || bus_req !== 1'b0) begin
      nerr++; $display("FAIL both_mem_ack got mem_ack %b rdata %h if_ack %b req %b want 1 0 0 0",
        mem_ack, mem_rdata, if_ack, bus_req);
    end
    mem_req = 0; mem_we = 0;
    @(negedge clk);
    nvec++;
    if ({bus_req, bus_we, bus_addr, bus_wdata, bus_sel} !== {1'b1, 1'b0, 32'h300, 32'h0, 4'hF}) begin
      nerr++; $display("FAIL both_if_cmd got req %b we %b addr %h wdata %h sel %h want 1 0 300 0 f",
        bus_req, bus_we, bus_addr, bus_wdata, bus_sel);
    end
    repeat (2) @(negedge clk);
    nvec++;
    if (if_ack !== 1'b1 || if_rdata !== 32'h55AA55AA || mem_ack !== 1'b0) begin
      nerr++; $display("FAIL both_if_ack got if_ack %b rdata %h mem_ack %b want 1 55aa55aa 0",
        if_ack, if_rdata, mem_ack);
    end
    if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_streak;
    int nacks, cyc;
    logic exp_if;
    @(negedge clk);
    mem_lat = 2; mdl_rdata = 32'h0;
    if_req = 1; if_addr = 32'h104;
    mem_req = 1; mem_we = 0; mem_addr = 32'h400;
    nacks = 0; cyc = 0;
    while (nacks < 10 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (if_ack || mem_ack) begin
        exp_if = (nacks % 5 == 4);
        nvec++;
        if (if_ack !== exp_if || mem_ack !== !exp_if) begin
          nerr++; $display("FAIL streak_order grant %0d got if_ack %b mem_ack %b want if_ack %b",
            nacks, if_ack, mem_ack, exp_if);
        end
        nacks++;
      end
    end
    if_req = 0; mem_req = 0;
    nvec++;
    if (nacks != 10) begin
      nerr++; $display("FAIL streak_count got %0d acks want 10", nacks);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int lat;
    logic got;
    @(negedge clk);
    mem_lat = 0; mdl_rdata = 32'hFFFFFFFF;
    mem_req = 1; mem_we = 0; mem_addr = 32'h500;
    lat = 0; got = 0;
    while (!got && lat < 300) begin
      @(negedge clk); lat++;
      if (mem_ack) got = 1;
    end
    nvec++;
    if (!got || lat != 256) begin
      nerr++; $display("FAIL tmo_latency got ack %b after %0d cycles want 1 after 256", got, lat);
    end
    nvec++;
    if (bus_err !== 1'b1 || mem_rdata !== 32'h0 || bus_req !== 1'b0) begin
      nerr++; $display("FAIL tmo_err got err %b rdata %h req %b want 1 0 0", bus_err, mem_rdata, bus_req);
    end
    mem_req = 0;
    @(negedge clk);
    nvec++;
    if (bus_err !== 1'b0 || bus_req !== 1'b0 || mem_ack !== 1'b0) begin
      nerr++; $display("FAIL tmo_idle got err %b req %b ack %b want 0 0 0", bus_err, bus_req, mem_ack);
    end
    mem_lat = 2; mdl_rdata = 32'h0BADF00D;
    mem_req = 1; mem_addr = 32'h600;
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      @(negedge clk); lat++;
      if (mem_ack) got = 1;
    end
    nvec++;
    if (!got || lat != 3 || mem_rdata !== 32'h0BADF00D || bus_err !== 1'b0) begin
      nerr++; $display("FAIL tmo_recover got ack %b lat %0d rdata %h err %b want 1 3 0badf00d 0",
        got, lat, mem_rdata, bus_err);
    end
    mem_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int lat;
    logic got, stray;
    @(negedge clk);
    mem_lat = 7; mdl_rdata = 32'h11111111;
    mem_req = 1; mem_we = 0; mem_addr = 32'h700;
    @(negedge clk);
    nvec++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h700) begin
      nerr++; $display("FAIL rstmid_start got req %b addr %h want 1 700", bus_req, bus_addr);
    end
    @(negedge clk);
    rst = 1; if_req = 1; if_addr = 32'h800;
    #1;
    nvec++;
    if (stallreq_mem !== 1'b0 || stallreq_if !== 1'b0) begin
      nerr++; $display("FAIL rstmid_stall got if %b mem %b want 0 0", stallreq_if, stallreq_mem);
    end
    @(negedge clk);
    nvec++;
    if (bus_req !== 1'b0 || mem_ack !== 1'b0 || bus_err !== 1'b0) begin
      nerr++; $display("FAIL rstmid_drop got req %b ack %b err %b want 0 0 0", bus_req, mem_ack, bus_err);
    end
    @(negedge clk);
    rst = 0; mem_req = 0; mem_lat = 2; mdl_rdata = 32'h13579BDF;
    #1;
    nvec++;
    if (stallreq_if !== 1'b1 || mem_ack !== 1'b0) begin
      nerr++; $display("FAIL rstmid_release got stall_if %b mem_ack %b want 1 0", stallreq_if, mem_ack);
    end
    lat = 0; got = 0; stray = 0;
    while (!got && lat < 20) begin
      @(negedge clk); lat++;
      if (mem_ack) stray = 1;
      if (if_ack) got = 1;
    end
    nvec++;
    if (!got || lat != 3 || if_rdata !== 32'h13579BDF || stray) begin
      nerr++; $display("FAIL rstmid_if got ack %b lat %0d rdata %h stray_mem_ack %b want 1 3 13579bdf 0",
        got, lat, if_rdata, stray);
    end
    if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_idle_ack;
    int lat;
    logic got;
    @(negedge clk);
    mem_lat = 0; man_ack = 1;
    @(negedge clk);
    man_ack = 0;
    nvec++;
    if ({bus_req, if_ack, mem_ack, bus_err} !== 4'b0) begin
      nerr++; $display("FAIL idle_ack got req %b if_ack %b mem_ack %b err %b want 0 0 0 0",
        bus_req, if_ack, mem_ack, bus_err);
    end
    mem_lat = 255; mdl_rdata = 32'hCAFEF00D;
    mem_req = 1; mem_we = 0; mem_addr = 32'h900;
    lat = 0; got = 0;
    while (!got && lat < 300) begin
      @(negedge clk); lat++;
      if (mem_ack) got = 1;
    end
    nvec++;
    if (!got || lat != 256 || bus_err !== 1'b0 || mem_rdata !== 32'hCAFEF00D) begin
      nerr++; $display("FAIL edge_ack got ack %b lat %0d err %b rdata %h want 1 256 0 cafef00d",
        got, lat, bus_err, mem_rdata);
    end
    mem_req = 0;
    @(negedge clk);
  endtask

  initial begin
    nvec = 0; nerr = 0;
    test_reset();
    test_lone_if();
    test_mem_before_if();
    test_streak();
    test_timeout();
    test_reset_mid();
    test_idle_ack();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
